pc_stack_unit: RTL and testbench
================================

Name: pc_stack_unit

Overview:
- Parametrised successor to the 16-bit loadable program counter.
- Generates the instruction fetch address with:
  - sequential increment
  - absolute load (jump)
  - signed relative branch
  - call/return through an internal hardware return-address stack
- Sits between the control unit and instruction memory. Adds stall, stack status and a sticky error flag that the previous generation lacked.

Parameters:
- WIDTH, 16: address width in bits.
- STEP, 1: increment applied per advance; also the return offset pushed on call.
- DEPTH, 8: return-stack entries; must be at least 2.
- RESET_VEC, 0: value loaded into out on reset.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-low reset.
- hold, input, 1: stall. When high, PC and stack are frozen and all commands are ignored.
- en, input, 1: advance enable, out <= out + STEP.
- ld_sig, input, 1: absolute load, out <= ld_in.
- ld_in, input, WIDTH: load target; also the call target.
- br_sig, input, 1: relative branch.
- br_off, input, WIDTH: two's-complement branch offset.
- call_sig, input, 1: push return address, then jump to ld_in.
- ret_sig, input, 1: pop return address into out.
- out, output, WIDTH: current PC, registered.
- sp, output, $clog2(DEPTH+1): number of valid stack entries.
- stk_full, output, 1: high when sp == DEPTH.
- stk_empty, output, 1: high when sp == 0.
- stk_err, output, 1: sticky overflow/underflow flag.

Behaviour:
- All state updates on the rising clk edge. Every output is registered or decoded from registered state; no combinational input-to-output path.
- Reset (rst == 0 at a clock edge):
  - out = RESET_VEC, sp = 0, stk_empty = 1, stk_full = 0, stk_err = 0.
  - Stack contents are don't-care.
  - Reset overrides hold and all commands, including mid-sequence; an in-progress call chain is discarded.
- hold == 1 with rst == 1: no state changes.
- Otherwise exactly one action per cycle, in strict priority order:
  1. ld_sig: out <= ld_in. Stack unchanged.
  2. call_sig:
     - If sp < DEPTH: stack[sp] <= out + STEP, sp <= sp + 1.
     - If sp == DEPTH: push dropped, stk_err <= 1, sp unchanged.
     - In both cases out <= ld_in.
  3. ret_sig:
     - If sp > 0: out <= stack[sp-1], sp <= sp - 1.
     - If sp == 0: out <= out + STEP, stk_err <= 1.
  4. br_sig: out <= out + br_off, modulo 2^WIDTH. The offset is signed, so an all-ones offset decrements by 1.
  5. en: out <= out + STEP, modulo 2^WIDTH.
  6. None of the above asserted: out holds.
- Simultaneous commands: the lower-priority command is fully ignored, with no side effects.
  - Example: call_sig and ret_sig together perform only the call.
- Arithmetic: all additions truncate to WIDTH bits and wrap silently. Wrap-around is not an error.
- Return address = the PC value at the call cycle + STEP, truncated to WIDTH.
- Stack order: LIFO. Push and pop never occur in the same cycle, by priority.
- stk_err: cleared only by reset; never self-clears.
- Latency: one cycle from command sampled to new out visible.

Test Plan:
- Reset and count (WIDTH=16, STEP=1, RESET_VEC=0):
  - rst=0 for 1 cycle -> out=0x0000, sp=0, stk_empty=1, stk_err=0.
  - rst=1, en=1 for 4 cycles -> out = 1, 2, 3, 4.
- Load and wrap:
  - ld_sig=1, ld_in=20 -> out=20; then en -> 21.
  - ld_in=0xFFFF, then en -> out=0x0000, stk_err stays 0.
- Branch:
  - out=0x0010, br_sig=1, br_off=0xFFFE -> out=0x000E.
  - br_off=0x0005 -> out=0x0013.
  - br_sig=1 with en=1 -> branch only.
- Call/return (DEPTH=4):
  - out=20, call_sig=1, ld_in=0x0100 -> out=0x0100, sp=1.
  - ret_sig=1 -> out=21, sp=0, stk_empty=1.
- Overflow and underflow (DEPTH=4):
  - Five nested calls to 0x0200..0x0204 -> sp stops at 4, stk_full=1, stk_err=1 after the 5th call, out=0x0204.
  - Four rets -> LIFO addresses 0x0203, 0x0202, 0x0201, 21.
  - Fifth ret -> out = previous + 1, stk_err remains 1.
- Hold and reset mid-operation:
  - hold=1 with ld_sig=1, ld_in=0x55 -> out and sp unchanged.
  - With sp=3, assert rst=0 together with call_sig=1 -> out=RESET_VEC, sp=0, stk_err=0.

Source files
------------

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with increment, absolute load, signed relative
// branch and call/return through an internal return-address stack. Adds stall,
// stack occupancy/status outputs and a sticky overflow/underflow error flag.
module pc_stack_unit #(
  parameter int               WIDTH     = 16,
  parameter int               STEP      = 1,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hold,
  input  logic                       en,
  input  logic                       ld_sig,
  input  logic [WIDTH-1:0]           ld_in,
  input  logic                       br_sig,
  input  logic [WIDTH-1:0]           br_off,
  input  logic                       call_sig,
  input  logic                       ret_sig,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stk_full,
  output logic                       stk_empty,
  output logic                       stk_err
);

  localparam int               SPW     = $clog2(DEPTH + 1);
  localparam int               IDXW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
  localparam logic [SPW-1:0]   DEPTH_V = SPW'(DEPTH);
  localparam logic [SPW-1:0]   ONE_SP  = SPW'(1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;
  logic             push_en;
  logic [IDXW-1:0]  push_idx;
  logic [IDXW-1:0]  top_idx;
  logic [WIDTH-1:0] pc_inc;

  // Return addresses; contents are don't-care after reset, so no reset on the array.
  logic [WIDTH-1:0] stack_q [DEPTH];

  // The increment doubles as the return address pushed on call.
  assign pc_inc   = pc_q + STEP_V;
  // sp never exceeds DEPTH-1 when a push happens, so truncation is lossless.
  assign push_idx = IDXW'(sp_q);
  // Only used when sp_q > 0, so sp_q - 1 never wraps in practice.
  assign top_idx  = IDXW'(sp_q - ONE_SP);

  // Next-state selection: one action per cycle in fixed priority, none while stalled.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (!hold) begin
      if (ld_sig) begin
        pc_d = ld_in;
      end else if (call_sig) begin
        pc_d = ld_in;
        if (sp_q < DEPTH_V) begin
          push_en = 1'b1;
          sp_d    = sp_q + ONE_SP;
        end else begin
          // Overflow: return address is lost, but the jump still happens.
          err_d = 1'b1;
        end
      end else if (ret_sig) begin
        if (sp_q != '0) begin
          pc_d = stack_q[top_idx];
          sp_d = sp_q - ONE_SP;
        end else begin
          // Underflow: nothing to return to, so fall through to the next address.
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (br_sig) begin
        pc_d = pc_q + br_off;
      end else if (en) begin
        pc_d = pc_inc;
      end
    end
  end

  // PC, stack pointer and sticky error register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack write port; a push is suppressed in a reset cycle so a call chain is discarded.
  always_ff @(posedge clk) begin
    if (rst && push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign out       = pc_q;
  assign sp        = sp_q;
  assign stk_full  = (sp_q == DEPTH_V);
  assign stk_empty = (sp_q == '0);
  assign stk_err   = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit (WIDTH=16, STEP=1, DEPTH=4, RESET_VEC=0).
// Stimulus pushes hand-computed expectations tagged with the clock edge they
// belong to; a monitor on the falling edge pops and compares them.
module tb_pc_stack_unit;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst, hold, en, ld_sig, br_sig, call_sig, ret_sig;
  logic [W-1:0] ld_in, br_off;
  logic [W-1:0] out;
  logic [2:0]   sp;
  logic         stk_full, stk_empty, stk_err;

  typedef struct {
    int           cyc;
    logic [W-1:0] out;
    logic [2:0]   sp;
    logic         full;
    logic         empty;
    logic         err;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc       = 0;
  int   n_cmp     = 0;
  int   n_fail    = 0;

  pc_stack_unit #(.WIDTH(W), .STEP(1), .DEPTH(D), .RESET_VEC(16'h0000)) dut (
    .clk(clk), .rst(rst), .hold(hold), .en(en), .ld_sig(ld_sig), .ld_in(ld_in),
    .br_sig(br_sig), .br_off(br_off), .call_sig(call_sig), .ret_sig(ret_sig),
    .out(out), .sp(sp), .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every expectation due at the latest rising edge is checked here.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (out !== e.out || sp !== e.sp || stk_full !== e.full ||
          stk_empty !== e.empty || stk_err !== e.err) begin
        n_fail++;
        $display("FAIL %s: got out=%h sp=%0d full=%b empty=%b err=%b, want out=%h sp=%0d full=%b empty=%b err=%b",
                 e.name, out, sp, stk_full, stk_empty, stk_err,
                 e.out, e.sp, e.full, e.empty, e.err);
      end else begin
        $display("ok   %s: out=%h sp=%0d full=%b empty=%b err=%b",
                 e.name, out, sp, stk_full, stk_empty, stk_err);
      end
    end
  end

  // One clock cycle of stimulus with its expected post-edge state.
  task automatic step(input logic r, input logic h, input logic e_i, input logic l,
                      input logic [W-1:0] li, input logic b, input logic [W-1:0] bo,
                      input logic c, input logic rt,
                      input logic [W-1:0] x_out, input int x_sp, input logic x_err,
                      input string name);
    exp_t x;
    rst = r; hold = h; en = e_i; ld_sig = l; ld_in = li;
    br_sig = b; br_off = bo; call_sig = c; ret_sig = rt;
    x.cyc   = cyc + 1;
    x.out   = x_out;
    x.sp    = 3'(x_sp);
    x.full  = (x_sp == D);
    x.empty = (x_sp == 0);
    x.err   = x_err;
    x.name  = name;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //    rst hold en  ld  ld_in     br  br_off    cal ret  out       sp err
    step(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, "reset");
    step(1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0001, 0, 0, "count1");
    step(1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0002, 0, 0, "count2");
    step(1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0003, 0, 0, "count3");
    step(1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0004, 0, 0, "count4");
    step(1, 0, 0, 1, 16'd20,   0, 16'h0000, 0, 0, 16'd20,   0, 0, "load20");
    step(1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'd21,   0, 0, "inc21");
    step(1, 0, 0, 1, 16'hFFFF, 0, 16'h0000, 0, 0, 16'hFFFF, 0, 0, "loadFFFF");
    step(1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, "incwrap");
    step(1, 0, 0, 1, 16'h0010, 0, 16'h0000, 0, 0, 16'h0010, 0, 0, "load10");
    step(1, 0, 0, 0, 16'h0000, 1, 16'hFFFE, 0, 0, 16'h000E, 0, 0, "br_neg2");
    step(1, 0, 0, 0, 16'h0000, 1, 16'h0005, 0, 0, 16'h0013, 0, 0, "br_pos5");
    step(1, 0, 1, 0, 16'h0000, 1, 16'h0005, 0, 0, 16'h0018, 0, 0, "br_over_en");
    step(1, 0, 1, 1, 16'd20,   1, 16'h0005, 0, 1, 16'd20,   0, 0, "ld_over_all");
    step(1, 0, 0, 0, 16'h0100, 0, 16'h0000, 1, 0, 16'h0100, 1, 0, "call100");
    step(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'd21,   0, 0, "ret21");
    step(1, 0, 1, 0, 16'h0300, 1, 16'h0040, 1, 1, 16'h0300, 1, 0, "call_over_ret");
    step(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'd22,   0, 0, "ret22");
    step(1, 0, 0, 1, 16'd20,   0, 16'h0000, 0, 0, 16'd20,   0, 0, "load20b");
    step(1, 0, 0, 0, 16'h0200, 0, 16'h0000, 1, 0, 16'h0200, 1, 0, "call200");
    step(1, 0, 0, 0, 16'h0201, 0, 16'h0000, 1, 0, 16'h0201, 2, 0, "call201");
    step(1, 0, 0, 0, 16'h0202, 0, 16'h0000, 1, 0, 16'h0202, 3, 0, "call202");
    step(1, 0, 0, 0, 16'h0203, 0, 16'h0000, 1, 0, 16'h0203, 4, 0, "call203_full");
    step(1, 0, 0, 0, 16'h0204, 0, 16'h0000, 1, 0, 16'h0204, 4, 1, "call204_ovf");
    step(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0203, 3, 1, "ret203");
    step(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0202, 2, 1, "ret202");
    step(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0201, 1, 1, "ret201");
    step(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'd21,   0, 1, "ret21b");
    step(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'd22,   0, 1, "ret_udf");
    step(1, 1, 0, 1, 16'h0055, 0, 16'h0000, 0, 0, 16'd22,   0, 1, "hold_ld");
    step(1, 1, 1, 0, 16'h0077, 1, 16'h0003, 1, 1, 16'd22,   0, 1, "hold_all");
    step(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, "reset2");
    step(1, 0, 0, 0, 16'h0010, 0, 16'h0000, 1, 0, 16'h0010, 1, 0, "callA");
    step(1, 0, 0, 0, 16'h0020, 0, 16'h0000, 1, 0, 16'h0020, 2, 0, "callB");
    step(1, 0, 0, 0, 16'h0030, 0, 16'h0000, 1, 0, 16'h0030, 3, 0, "callC");
    step(0, 0, 0, 0, 16'h0040, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, "rst_over_call");
    step(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0001, 0, 1, "ret_udf2");
    step(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, "rst_over_hold");
    step(1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0001, 0, 0, "inc_after_rst");
    step(1, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 0, 16'h0000, 0, 0, "br_m1");
    step(1, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 0, 16'hFFFF, 0, 0, "br_m1_wrap");
    step(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'hFFFF, 0, 0, "idle");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
